pwm_audio_stream: RTL

Streaming PWM audio output stage. Accepts packed sample words over a valid/ready handshake, buffers them in an internal FIFO, and plays each sample, MSB-first, as one PWM period of 2^SAMPLE_W steps at a programmable step rate. Underrun is handled explicitly: output holds mid-scale and a status pulse is raised. It sits between the audio sample source (CPU/DMA register interface) and the board audio pin.

---
 rtl/pwm_audio_stream.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pwm_audio_stream.sv
// Streaming PWM audio output: word FIFO feeding a per-sample PWM generator
// with programmable step rate and explicit mid-scale underrun handling.
module pwm_audio_stream #(
  parameter int unsigned SAMPLE_W         = 8,
  parameter int unsigned SAMPLES_PER_WORD = 4,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned PRESCALE_W       = 8,
  localparam int unsigned DATA_W          = SAMPLE_W * SAMPLES_PER_WORD,
  localparam int unsigned LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aud_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  pwm,
  output logic                  underrun,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  busy
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned IDX_W = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(SAMPLES_PER_WORD - 1);
  localparam logic [SAMPLE_W-1:0] CNT_MAX  = '1;
  localparam logic [SAMPLE_W-1:0] MID      = SAMPLE_W'(1) << (SAMPLE_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_STARVE} state_t;

  // ---------------- input FIFO ----------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_d;
  logic [DATA_W-1:0] head;
  logic              push, pop, fifo_empty;

  assign push       = s_valid && s_ready;
  assign fifo_empty = (fifo_level == '0);
  assign head       = mem[rd_ptr];

  always_comb begin
    level_d = fifo_level;
    if (push && !pop)      level_d = fifo_level + LVL_W'(1);
    else if (!push && pop) level_d = fifo_level - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // s_ready is registered from the next level, so a pop while full does not reopen it early
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      s_ready    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_d;
      s_ready    <= (level_d != LVL_W'(FIFO_DEPTH));
    end
  end

  // ---------------- playback FSM ----------------
  state_t                state, state_d;
  logic [PRESCALE_W-1:0] pcnt, pcnt_d;
  logic [SAMPLE_W-1:0]   cnt, cnt_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [DATA_W-1:0]     word, word_d;
  logic [SAMPLE_W-1:0]   duty;
  logic                  tick, period_end, pwm_d, underrun_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    pcnt_d     = pcnt;
    cnt_d      = cnt;
    idx_d      = idx;
    word_d     = word;
    pop        = 1'b0;
    underrun_d = 1'b0;
    tick       = (pcnt >= prescale);
    period_end = tick && (cnt == CNT_MAX);
    duty       = (state == ST_PLAY) ? word[DATA_W-1 -: SAMPLE_W] : MID;
    pwm_d      = (state != ST_IDLE) && aud_en && (cnt < duty);

    if (!aud_en) begin
      state_d = ST_IDLE;
      pcnt_d  = '0;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          pcnt_d = '0;
          cnt_d  = '0;
          idx_d  = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            word_d  = head;
            state_d = ST_PLAY;
          end
        end
        ST_PLAY: begin
          pcnt_d = tick ? '0 : pcnt + PRESCALE_W'(1);
          cnt_d  = tick ? cnt + SAMPLE_W'(1) : cnt;
          if (period_end) begin
            if (idx == IDX_LAST) begin
              idx_d = '0;
              if (!fifo_empty) begin
                pop    = 1'b1;
                word_d = head;
              end else begin
                state_d    = ST_STARVE;
                underrun_d = 1'b1;
              end
            end else begin
              // current sample always sits in the top bits of word
              idx_d  = idx + IDX_W'(1);
              word_d = word << SAMPLE_W;
            end
          end
        end
        ST_STARVE: begin
          pcnt_d = tick ? '0 : pcnt + PRESCALE_W'(1);
          cnt_d  = tick ? cnt + SAMPLE_W'(1) : cnt;
          if (period_end && !fifo_empty) begin
            pop     = 1'b1;
            word_d  = head;
            idx_d   = '0;
            state_d = ST_PLAY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt     <= '0;
      cnt      <= '0;
      idx      <= '0;
      word     <= '0;
      pwm      <= 1'b0;
      underrun <= 1'b0;
      busy     <= 1'b0;
    end else begin
      pcnt     <= pcnt_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      word     <= word_d;
      pwm      <= pwm_d;
      underrun <= underrun_d;
      busy     <= (state_d != ST_IDLE);
    end
  end

endmodule
